fifo_line_ctrl: RTL

- Sequencing controller that turns one external `fifo_sync` instance into a one-line pixel delay for the image pipeline.
- Accepts a raster pixel stream and fills the FIFO with the first line. It then pairs every new pixel with the pixel directly above it, for vertical kernels.
- At end of frame it empties the FIFO so the next frame starts clean.
- Sits between the pixel source and the vertical-window stage; owns all `wr_en`/`rd_en` decisions for its FIFO.

---
 rtl/fifo_line_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fifo_line_ctrl.sv
// fifo_line_ctrl
// ----------------------------------------------------------------------------
// Turns an external first-word-fall-through fifo_sync into a one-line pixel
// delay. The first line of a frame primes the FIFO. Each later pixel is then
// paired with the pixel one line above it, which is the FIFO head. At end of
// frame the FIFO is emptied so the next frame starts clean.
//
// Ports
//   clk, reset              single clock, synchronous active-high reset
//   s_valid/s_ready/s_data  input pixel stream; s_eof marks the last pixel
//   m_valid/m_ready         output pair handshake
//   m_cur, m_prev           current pixel / pixel one line above
//   fifo_*                  attached FIFO: write/read strobes, data, status
//   err                     sticky error flag, cleared only by reset
//
// Build option
//   FIFO_LINE_CTRL_DRAIN_EN  defined: the end-of-frame flush emits each popped
//                            entry as a pair (m_cur=0, m_prev=head), which
//                            gives bottom-padding rows. Undefined: popped
//                            entries are discarded at one per cycle.
//
// state  | meaning
// PRIME  | first line of the frame is being written into the FIFO
// STREAM | pop head + push pixel each accepted beat, emit the (cur, prev) pair
// FLUSH  | end of frame: pop until the FIFO is empty, then go back to PRIME
module fifo_line_ctrl #(
    parameter int DATA_W    = 10,
    parameter int LINE_W    = 640,
    parameter int FIFO_SIZE = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       s_valid,
    input  logic [DATA_W-1:0]          s_data,
    input  logic                       s_eof,
    output logic                       s_ready,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_cur,
    output logic [DATA_W-1:0]          m_prev,
    output logic [DATA_W-1:0]          fifo_data_wr,
    output logic                       fifo_wr_en,
    input  logic [DATA_W-1:0]          fifo_data_rd,
    output logic                       fifo_rd_en,
    input  logic [$clog2(FIFO_SIZE):0] fifo_data_count,
    input  logic                       fifo_empty,
    input  logic                       fifo_full,
    input  logic                       fifo_overflow,
    input  logic                       fifo_underflow,
    output logic                       err
);

    localparam int CNT_W = $clog2(FIFO_SIZE) + 1;
    localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(LINE_W - 1);
    localparam logic [CNT_W-1:0] LINE_CNT  = CNT_W'(LINE_W);

    typedef enum logic [1:0] {PRIME, STREAM, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic                m_valid_q, m_valid_d;
    logic [DATA_W-1:0]   m_cur_q, m_cur_d;
    logic [DATA_W-1:0]   m_prev_q, m_prev_d;
    logic                err_q, err_d;
    logic                entry_q, entry_d;
    logic                accept;
    logic                load;
    logic [DATA_W-1:0]   load_cur;

    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        s_ready      = 1'b0;
        accept       = 1'b0;
        fifo_wr_en   = 1'b0;
        fifo_rd_en   = 1'b0;
        fifo_data_wr = s_data;
        load         = 1'b0;
        load_cur     = s_data;
        entry_d      = 1'b0;

        // Strobes are combinational, so reset must mask them directly.
        if (!reset) begin
            case (state_q)
                PRIME: begin
                    s_ready = !fifo_full;
                    accept  = s_valid && s_ready;
                    if (accept) begin
                        fifo_wr_en = 1'b1;
                        if (s_eof) begin
                            state_d   = FLUSH;
                            pix_cnt_d = '0;
                        end else if (pix_cnt_q == LINE_LAST) begin
                            state_d   = STREAM;
                            pix_cnt_d = '0;
                            entry_d   = 1'b1;
                        end else begin
                            pix_cnt_d = pix_cnt_q + CNT_W'(1);
                        end
                    end
                end
                STREAM: begin
                    s_ready = !m_valid_q || m_ready;
                    accept  = s_valid && s_ready;
                    if (accept) begin
                        // Pop and push together keep occupancy at one line; a
                        // full FIFO only accepts the push when the pop happens.
                        fifo_rd_en = !fifo_empty;
                        fifo_wr_en = !fifo_full || fifo_rd_en;
                        load       = 1'b1;
                        if (s_eof) begin
                            state_d = FLUSH;
                        end
                    end
                end
                FLUSH: begin
`ifdef FIFO_LINE_CTRL_DRAIN_EN
                    if (!fifo_empty && (!m_valid_q || m_ready)) begin
                        fifo_rd_en = 1'b1;
                        load       = 1'b1;
                        load_cur   = '0;
                    end
`else
                    fifo_rd_en = !fifo_empty;
`endif
                    if (fifo_empty) begin
                        state_d   = PRIME;
                        pix_cnt_d = '0;
                    end
                end
                default: state_d = PRIME;
            endcase
        end

        m_valid_d = load ? 1'b1 : (m_ready ? 1'b0 : m_valid_q);
        m_cur_d   = load ? load_cur : m_cur_q;
        m_prev_d  = load ? fifo_data_rd : m_prev_q;

        // entry_q marks the first STREAM cycle, when the count already shows
        // the last priming write.
        err_d = err_q || fifo_overflow || fifo_underflow ||
                (entry_q && (fifo_data_count != LINE_CNT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= PRIME;
            pix_cnt_q <= '0;
            m_valid_q <= 1'b0;
            m_cur_q   <= '0;
            m_prev_q  <= '0;
            err_q     <= 1'b0;
            entry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            m_valid_q <= m_valid_d;
            m_cur_q   <= m_cur_d;
            m_prev_q  <= m_prev_d;
            err_q     <= err_d;
            entry_q   <= entry_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_cur   = m_cur_q;
    assign m_prev  = m_prev_q;
    assign err     = err_q;

endmodule
